// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the UART transmit path.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_parity_calc.sv
// Combinational frame parity: XOR of all data bits, inverted for odd parity.
module parity_calc #(
  parameter int FRAME_WIDTH = 8
) (
  input  logic [FRAME_WIDTH-1:0] data,
  input  logic                   par_typ,
  output logic                   par_bit
);

  assign par_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART frame controller: sequences start/data/parity/stop bits and drives the
// shifter enable, producing a registered serial line that idles high.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int FRAME_WIDTH   = 8,
  parameter int COUNTER_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Data_Valid,
  input  logic [FRAME_WIDTH-1:0] P_Data,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic                   ser_data,
  output logic                   ser_en,
  output logic                   TX_OUT,
  output logic                   Busy
);

  localparam logic [COUNTER_WIDTH-1:0] LAST_BIT = COUNTER_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);

  tx_state_e                state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                     par_bit_q, par_bit_d;
  logic                     par_en_q, par_en_d;
  logic                     tx_q, tx_d;
  logic                     accept;
  logic                     par_calc;

  parity_calc #(
    .FRAME_WIDTH(FRAME_WIDTH)
  ) u_parity_calc (
    .data   (P_Data),
    .par_typ(PAR_TYP),
    .par_bit(par_calc)
  );

  assign accept = Data_Valid && ((state_q == IDLE) || (state_q == STOP));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      tx_q      <= STOP_BIT;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    ser_en    = 1'b0;
    tx_d      = STOP_BIT;

    case (state_q)
      IDLE: begin
        tx_d = STOP_BIT;
        if (accept) state_d = START;
      end
      START: begin
        tx_d    = START_BIT;
        ser_en  = 1'b1;
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        tx_d = ser_data;
        // The last data cycle needs no further shift: FRAME_WIDTH pulses total.
        ser_en = (cnt_q != LAST_BIT);
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PARITY: begin
        tx_d    = par_bit_q;
        state_d = STOP;
      end
      STOP: begin
        tx_d    = STOP_BIT;
        state_d = accept ? START : IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // PAR_TYP is folded into the latched parity bit at accept time.
    if (accept) begin
      par_bit_d = par_calc;
      par_en_d  = PAR_EN;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: frame-level reference model, shifter
// model, directed scenarios and randomized traffic.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Data_Valid = 1'b0;
  logic [7:0] P_Data = 8'h00;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       ser_data = 1'b0;
  logic       ser_en;
  logic       TX_OUT;
  logic       Busy;

  uart_tx_ctrl #(
    .FRAME_WIDTH  (8),
    .COUNTER_WIDTH(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Data_Valid(Data_Valid),
    .P_Data    (P_Data),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .ser_data  (ser_data),
    .ser_en    (ser_en),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: expected outputs per absolute cycle number.
  logic exp_tx[int];
  logic exp_busy[int];
  logic exp_se[int];
  logic tx_log[int];
  logic busy_log[int];
  logic se_log[int];
  int   cyc = 0;
  int   stop_cyc = -1;
  logic chk_en = 1'b0;
  logic sh_load = 1'b0;

  function automatic logic get_bit(input logic arr[int], input int k, input logic dflt);
    if (arr.exists(k)) return arr[k];
    return dflt;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic       frame[$];
      int         len;
      check("tx_out", 32'(TX_OUT), 32'(get_bit(exp_tx, cyc, 1'b1)));
      check("busy", 32'(Busy), 32'(get_bit(exp_busy, cyc, 1'b0)));
      check("ser_en", 32'(ser_en), 32'(get_bit(exp_se, cyc, 1'b0)));
      tx_log[cyc]   = TX_OUT;
      busy_log[cyc] = Busy;
      se_log[cyc]   = ser_en;
      sh_load = Data_Valid && (cyc >= stop_cyc);
      if (sh_load) begin
        frame = {};
        frame.push_back(1'b0);
        for (int i = 0; i < 8; i++) frame.push_back(P_Data[i]);
        if (PAR_EN) frame.push_back((^P_Data) ^ PAR_TYP);
        frame.push_back(1'b1);
        len = frame.size();
        for (int k = 0; k < len; k++) begin
          exp_tx[cyc + 2 + k]   = frame[k];
          exp_busy[cyc + 1 + k] = 1'b1;
        end
        for (int k = 1; k <= 8; k++) exp_se[cyc + k] = 1'b1;
        stop_cyc = cyc + len;
      end
    end else begin
      sh_load = 1'b0;
    end
    cyc++;
  end

  // Registered shifter model: bit i appears one cycle after the i-th enable.
  logic [7:0] sh_buf = 8'h00;
  int         sh_idx = 0;
  always @(posedge clk) begin
    if (sh_load) begin
      sh_buf <= P_Data;
      sh_idx <= 0;
    end else if (ser_en) begin
      ser_data <= (sh_idx < 8) ? sh_buf[sh_idx] : 1'b0;
      sh_idx   <= sh_idx + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, output int a);
    int n = 0;
    while (cyc < stop_cyc && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("ready_timeout", 32'(n), 32'(0));
    Data_Valid = 1'b1;
    P_Data = d;
    PAR_EN = pe;
    PAR_TYP = pt;
    a = cyc;
    tick();
    Data_Valid = 1'b0;
    P_Data = 8'($urandom);
    PAR_EN = 1'($urandom);
    PAR_TYP = 1'($urandom);
  endtask

  function automatic int count_log(input logic arr[int], input int from, input int to);
    int c = 0;
    for (int k = from; k <= to; k++) if (arr.exists(k) && arr[k] === 1'b1) c++;
    return c;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int a;
    int s;
    int n;
    logic [10:0] lit;

    repeat (3) @(posedge clk);
    #3;
    check("rst_tx", 32'(TX_OUT), 32'(1));
    check("rst_busy", 32'(Busy), 32'(0));
    check("rst_ser_en", 32'(ser_en), 32'(0));
    reset = 1'b0;
    chk_en = 1'b1;
    tick();
    tick();

    // Even parity, 0xA5
    send(8'hA5, 1'b1, 1'b0, a);
    repeat (14) tick();
    lit = 11'b10101001010;
    for (int k = 0; k < 11; k++)
      check($sformatf("a5_bit%0d", k), 32'(get_bit(tx_log, a + 2 + k, 1'bx)), 32'(lit[k]));
    check("a5_busy_len", count_log(busy_log, a, a + 14), 11);
    check("a5_ser_en_cnt", count_log(se_log, a, a + 14), 8);

    // 0x01 odd / even / no parity
    send(8'h01, 1'b1, 1'b1, a);
    repeat (13) tick();
    check("01_odd_par", 32'(get_bit(tx_log, a + 11, 1'bx)), 32'(0));
    send(8'h01, 1'b1, 1'b0, a);
    repeat (13) tick();
    check("01_even_par", 32'(get_bit(tx_log, a + 11, 1'bx)), 32'(1));
    send(8'h01, 1'b0, 1'b0, a);
    repeat (13) tick();
    check("01_nopar_busy_len", count_log(busy_log, a, a + 13), 10);
    check("01_nopar_stop", 32'(get_bit(tx_log, a + 11, 1'bx)), 32'(1));

    // Back-to-back: 0x3C held, then 0xC3 in the STOP cycle
    n = 0;
    Data_Valid = 1'b1;
    P_Data = 8'h3C;
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    a = cyc;
    tick();
    while (cyc != stop_cyc && n < 50) begin
      tick();
      n++;
    end
    check("b2b_reach_stop", 32'(n < 50), 32'(1));
    s = cyc;
    P_Data = 8'hC3;
    tick();
    Data_Valid = 1'b0;
    repeat (15) tick();
    check("b2b_stop_len", s - a, 11);
    check("b2b_stop_bit", 32'(get_bit(tx_log, s + 1, 1'bx)), 32'(1));
    check("b2b_start_bit", 32'(get_bit(tx_log, s + 2, 1'bx)), 32'(0));
    check("b2b_busy_held", count_log(busy_log, s, s + 2), 3);

    // Busy ignore: 0xFF pulse mid-DATA must not disturb the frame
    send(8'h5A, 1'b1, 1'b1, a);
    while (cyc < a + 5) tick();
    Data_Valid = 1'b1;
    P_Data = 8'hFF;
    PAR_TYP = 1'b0;
    tick();
    Data_Valid = 1'b0;
    repeat (10) tick();
    check("ign_parity", 32'(get_bit(tx_log, a + 11, 1'bx)), 32'(1));
    check("ign_idle_after", 32'(get_bit(busy_log, a + 12, 1'bx)), 32'(0));

    // Reset during data bit 4
    send(8'h96, 1'b1, 1'b0, a);
    while (cyc < a + 6) tick();
    check("pre_rst_ser_en", 32'(ser_en), 32'(1));
    check("pre_rst_tx", 32'(TX_OUT), 32'(0));
    chk_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("mid_rst_tx", 32'(TX_OUT), 32'(1));
    check("mid_rst_ser_en", 32'(ser_en), 32'(0));
    check("mid_rst_busy", 32'(Busy), 32'(0));
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    exp_tx.delete();
    exp_busy.delete();
    exp_se.delete();
    stop_cyc = -1;
    chk_en = 1'b1;
    tick();
    send(8'h55, 1'b1, 1'b0, a);
    repeat (14) tick();
    check("55_bit0", 32'(get_bit(tx_log, a + 3, 1'bx)), 32'(1));
    check("55_bit1", 32'(get_bit(tx_log, a + 4, 1'bx)), 32'(0));
    check("55_parity", 32'(get_bit(tx_log, a + 11, 1'bx)), 32'(0));

    // Randomized traffic, including ignored strobes and back-to-back accepts
    for (int i = 0; i < 1500; i++) begin
      Data_Valid = ($urandom_range(0, 3) == 0);
      P_Data = 8'($urandom);
      PAR_EN = 1'($urandom);
      PAR_TYP = 1'($urandom);
      tick();
    end
    Data_Valid = 1'b0;
    repeat (15) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
